pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control block that sequences the program counter (PC) register.
- Decides the next instruction address every instruction cycle: sequential, branch, jump, call/return through an internal return-address stack, or interrupt vector.
- Drives PC's write-enable and new-address inputs; reads PC's current address back.
- Sits between the decode/execute logic and PC; PC itself is unchanged.

Parameters:
- ADDR_W, 9, address width; matches PC address/newAddr.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_VEC, 9'h000, address loaded after reset and on stack underflow.
- IRQ_VEC, 9'h1F0, interrupt entry address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold current instruction in EXEC.
- br_taken  in  1  conditional branch resolved taken.
- br_target  in  ADDR_W  branch destination.
- jump  in  1  unconditional jump.
- jump_target  in  ADDR_W  jump/call destination.
- call  in  1  push return address, go to jump_target.
- ret  in  1  pop return address.
- irq  in  1  interrupt request, level.
- pc_addr  in  ADDR_W  current PC address (from PC).
- pc_we  out  1  write enable to PC.
- pc_newAddr  out  ADDR_W  next address to PC.
- irq_ack  out  1  one-cycle interrupt accept pulse.
- in_isr  out  1  interrupt service active; irq masked.
- ras_overflow  out  1  sticky: push while full.
- ras_underflow  out  1  sticky: pop while empty.
- exec  out  1  high while in EXEC (control inputs sampled).

Behaviour:
- Reset (reset=0, async):
  - State BOOT.
  - pc_we=0, pc_newAddr=0, irq_ack=0, in_isr=0, both flags 0, exec=0.
  - RAS emptied (count=0, pointer=0).
- All outputs are registered. No combinational path from inputs to outputs.
- BOOT:
  - First rising edge after reset release: pc_we<=1, pc_newAddr<=RESET_VEC, go to FETCH.
- FETCH: one cycle.
  - pc_we pulse from the previous edge is visible here; PC updates at the end of FETCH.
  - Next edge: pc_we<=0, go to EXEC.
- EXEC:
  - exec=1; pc_addr is valid.
  - Control inputs are sampled on the edge leaving EXEC.
  - stall=1: remain in EXEC; pc_we stays 0; no RAS change; irq not taken.
  - stall=0: select the next address with the priority below, register pc_we<=1 and pc_newAddr, go to FETCH.
- Next-address priority, highest first:
  1. irq && !in_isr:
     - push (pc_addr+1), target IRQ_VEC.
     - irq_ack<=1 for exactly one cycle; in_isr<=1.
     - All other controls that cycle are ignored.
  2. ret:
     - pop, target = popped value.
     - If in_isr=1, clear in_isr (the return ends the ISR).
     - If the stack is empty: target RESET_VEC, ras_underflow<=1, count stays 0.
  3. call: push (pc_addr+1), target jump_target.
  4. jump: target jump_target.
  5. br_taken: target br_target.
  6. Otherwise: pc_addr+1.
- Simultaneous controls: only the highest-priority request acts. For example, call+ret together = ret only, with no push.
- Arithmetic:
  - pc_addr+1 is modulo 2^ADDR_W: 9'h1FF -> 9'h000.
  - The same applies to a pushed return address (call at 9'h1FF pushes 9'h000).
- RAS:
  - Circular LIFO.
  - Push when count=RAS_DEPTH: overwrite the oldest entry, count stays RAS_DEPTH, ras_overflow<=1.
  - Flags clear only on reset.
- Throughput: one instruction per 2 cycles (FETCH+EXEC) absent stalls.
- irq held while in_isr=1 is ignored until ret clears in_isr. A still-asserted irq is then taken at the next EXEC.
- Reset asserted mid-cycle (any state): immediate return to reset values. A pending pc_we pulse is dropped.

Test Plan:
1. Reset, release, no controls:
   - pc_we pulses with pc_newAddr=000 in the cycle after release.
   - Subsequent pulses every 2 cycles with 001, 002, 003.
   - exec high on alternate cycles.
2. EXEC with pc_addr=9'h010:
   - call, jump_target=9'h080 -> newAddr=080.
   - Later EXEC, ret -> newAddr=011.
   - call+ret same cycle -> ret only; stack depth unchanged apart from the pop.
3. Five nested calls from addresses 000..004, then five rets:
   - Returns 005, 004, 003, 002.
   - Fifth ret gives 000 (RESET_VEC) with ras_underflow=1.
   - ras_overflow=1 after the fifth call.
4. irq=1 with jump=1 at pc_addr=9'h020:
   - newAddr=1F0, irq_ack high for one cycle, in_isr=1, jump ignored.
   - irq held: no re-entry.
   - ret -> newAddr=021, in_isr=0.
5. stall=1 for 3 EXEC cycles with br_taken=1, br_target=9'h055:
   - No pc_we during the stall.
   - On release -> newAddr=055 once.
   - Separately, pc_addr=9'h1FF with no controls -> newAddr=000.
6. Assert reset while pc_we=1 in FETCH:
   - pc_we drops immediately; flags clear; RAS empty.
   - After release, BOOT reloads 000.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: picks the next program-counter address each instruction and drives the PC write port.
// The block boots to RESET_VEC and then alternates FETCH and EXEC. On the edge that leaves EXEC it chooses
// the next address from, highest priority first: interrupt, return, call, jump, taken branch, sequential.
// Ports:
//   clk, reset (async, active-low)
//   stall, br_taken/br_target, jump/jump_target, call, ret, irq   control inputs, sampled on the edge leaving EXEC
//   pc_addr                                                      current PC value
//   pc_we, pc_newAddr                                            registered PC write port
//   irq_ack, in_isr                                              interrupt accept pulse and service-active flag
//   ras_overflow, ras_underflow                                  sticky return-stack error flags
//   exec                                                         high while control inputs are being sampled
module pc_sequencer #(
    parameter int                 ADDR_W    = 9,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  IRQ_VEC   = 9'h1F0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
    input  logic              irq,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_newAddr,
    output logic              irq_ack,
    output logic              in_isr,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic              exec
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] pc_inc;
    logic [PW-1:0]     ptr_dec;
    logic              take_irq;
    logic              empty;
    logic              push;

    assign pc_inc   = pc_addr + 1'b1;
    assign ptr_dec  = ptr - 1'b1;
    assign take_irq = irq && !in_isr;
    assign empty    = count == '0;
    // A ret alongside a call wins, so the call must not push.
    assign push     = take_irq || (call && !ret);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            pc_we         <= 1'b0;
            pc_newAddr    <= '0;
            irq_ack       <= 1'b0;
            in_isr        <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            exec          <= 1'b0;
            ptr           <= '0;
            count         <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else begin
            pc_we   <= 1'b0;
            irq_ack <= 1'b0;
            case (state)
                BOOT: begin
                    pc_we      <= 1'b1;
                    pc_newAddr <= RESET_VEC;
                    state      <= FETCH;
                end
                FETCH: begin
                    exec  <= 1'b1;
                    state <= EXEC;
                end
                EXEC: if (!stall) begin
                    exec       <= 1'b0;
                    state      <= FETCH;
                    pc_we      <= 1'b1;
                    irq_ack    <= take_irq;
                    in_isr     <= take_irq ? 1'b1 : ret ? 1'b0 : in_isr;
                    pc_newAddr <= take_irq ? IRQ_VEC :
                                  ret ? (empty ? RESET_VEC : ras[ptr_dec]) :
                                  (call || jump) ? jump_target :
                                  br_taken ? br_target : pc_inc;
                    // When full, the write pointer sits on the oldest entry, so a push overwrites it.
                    if (push) begin
                        ras[ptr] <= pc_inc;
                        ptr      <= ptr + 1'b1;
                        if (count == FULL) ras_overflow <= 1'b1;
                        else count <= count + 1'b1;
                    end else if (ret) begin
                        if (empty) ras_underflow <= 1'b1;
                        else begin
                            ptr   <= ptr_dec;
                            count <= count - 1'b1;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven, directed and random checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;
    logic       clk = 0, reset = 1, stall = 0, br_taken = 0, jump = 0, call = 0, ret = 0, irq = 0;
    logic [8:0] br_target = '0, jump_target = '0, pc_reg;
    logic       pc_we, irq_ack, in_isr, ras_overflow, ras_underflow, exec;
    logic [8:0] pc_newAddr;

    int checks = 0, errors = 0;
    int mq[$];
    bit m_isr, m_ovf, m_unf;

    typedef struct {
        bit irq, ret, call, jump, br;
        logic [8:0] jt, bt, na;
        bit ack, isr, ovf, unf;
    } vec_t;
    vec_t tbl[$];

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target), .call(call), .ret(ret), .irq(irq),
        .pc_addr(pc_reg), .pc_we(pc_we), .pc_newAddr(pc_newAddr), .irq_ack(irq_ack),
        .in_isr(in_isr), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .exec(exec)
    );

    always #5 clk = ~clk;

    // The PC register the sequencer controls.
    always @(posedge clk or negedge reset)
        if (!reset) pc_reg <= '0;
        else if (pc_we) pc_reg <= pc_newAddr;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit i, bit r, bit c, bit j, bit b, logic [8:0] jt, logic [8:0] bt,
                                logic [8:0] na, bit ack, bit isr, bit ovf, bit unf);
        vec_t v;
        v.irq = i; v.ret = r; v.call = c; v.jump = j; v.br = b;
        v.jt = jt; v.bt = bt; v.na = na;
        v.ack = ack; v.isr = isr; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_isr = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void m_push(logic [8:0] v);
        mq.push_back(int'(v));
        if (mq.size() > 4) begin
            void'(mq.pop_front());
            m_ovf = 1;
        end
    endfunction

    // Runs one instruction: waits for EXEC, holds stall for ns cycles, then checks the chosen address against the model.
    task automatic instr(input bit i, input bit r, input bit c, input bit j, input bit b,
                         input logic [8:0] jt, input logic [8:0] bt, input int ns);
        int n = 0;
        logic [8:0] exp_na, pc;
        bit exp_ack;
        @(negedge clk);
        while (exec !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("exec_wait", exec, 1);
        chk("we_idle", pc_we, 0);
        chk("ack_width", irq_ack, 0);
        irq = i; ret = r; call = c; jump = j; br_taken = b; jump_target = jt; br_target = bt;
        stall = ns > 0;
        for (int k = 0; k < ns; k++) begin
            @(posedge clk);
            #1;
            chk("stall_we", pc_we, 0);
            chk("stall_exec", exec, 1);
        end
        stall = 0;
        pc = pc_reg;
        exp_ack = 0;
        if (i && !m_isr) begin
            m_push(pc + 9'd1);
            exp_na = 9'h1F0;
            exp_ack = 1;
            m_isr = 1;
        end else if (r) begin
            m_isr = 0;
            if (mq.size() == 0) begin
                exp_na = 9'h000;
                m_unf = 1;
            end else exp_na = 9'(mq.pop_back());
        end else if (c) begin
            m_push(pc + 9'd1);
            exp_na = jt;
        end else if (j) exp_na = jt;
        else if (b) exp_na = bt;
        else exp_na = pc + 9'd1;
        @(posedge clk);
        #1;
        irq = 0; ret = 0; call = 0; jump = 0; br_taken = 0;
        chk("m_we", pc_we, 1);
        chk("m_addr", pc_newAddr, exp_na);
        chk("m_ack", irq_ack, exp_ack);
        chk("m_isr", in_isr, m_isr);
        chk("m_ovf", ras_overflow, m_ovf);
        chk("m_unf", ras_underflow, m_unf);
        chk("m_exec", exec, 0);
    endtask

    initial begin
        tbl.push_back(mk(0,0,0,0,0, 9'h000, 9'h000, 9'h001, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 9'h000, 9'h000, 9'h002, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 9'h000, 9'h000, 9'h003, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 9'h010, 9'h000, 9'h010, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h080, 9'h000, 9'h080, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 9'h000, 9'h000, 9'h081, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h011, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h0A0, 9'h000, 9'h0A0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0, 9'h0C0, 9'h000, 9'h012, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 9'h000, 9'h000, 9'h000, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h001, 9'h000, 9'h001, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h002, 9'h000, 9'h002, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h003, 9'h000, 9'h003, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h004, 9'h000, 9'h004, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 9'h005, 9'h000, 9'h005, 0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h005, 0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h004, 0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h003, 0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h002, 0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h000, 0,0,1,1));
        tbl.push_back(mk(0,0,0,1,0, 9'h020, 9'h000, 9'h020, 0,0,1,1));
        tbl.push_back(mk(1,0,0,1,0, 9'h0AA, 9'h000, 9'h1F0, 1,1,1,1));
        tbl.push_back(mk(1,0,0,0,0, 9'h000, 9'h000, 9'h1F1, 0,1,1,1));
        tbl.push_back(mk(1,1,0,0,0, 9'h000, 9'h000, 9'h021, 0,0,1,1));
        tbl.push_back(mk(1,0,0,0,0, 9'h000, 9'h000, 9'h1F0, 1,1,1,1));
        tbl.push_back(mk(0,1,0,0,0, 9'h000, 9'h000, 9'h022, 0,0,1,1));
        tbl.push_back(mk(0,0,0,0,1, 9'h000, 9'h055, 9'h055, 0,0,1,1));
        tbl.push_back(mk(0,0,0,1,0, 9'h1FF, 9'h000, 9'h1FF, 0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0, 9'h000, 9'h000, 9'h000, 0,0,1,1));
        tbl.push_back(mk(0,0,0,1,1, 9'h100, 9'h055, 9'h100, 0,0,1,1));

        #3 reset = 0;
        m_reset();
        #4;
        chk("rst_we", pc_we, 0);
        chk("rst_addr", pc_newAddr, 0);
        chk("rst_ack", irq_ack, 0);
        chk("rst_isr", in_isr, 0);
        chk("rst_ovf", ras_overflow, 0);
        chk("rst_unf", ras_underflow, 0);
        chk("rst_exec", exec, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        chk("boot_we", pc_we, 1);
        chk("boot_addr", pc_newAddr, 9'h000);
        chk("boot_exec", exec, 0);
        @(posedge clk);
        #1;
        chk("fetch_we", pc_we, 0);
        chk("fetch_exec", exec, 1);

        foreach (tbl[r]) begin
            instr(tbl[r].irq, tbl[r].ret, tbl[r].call, tbl[r].jump, tbl[r].br, tbl[r].jt, tbl[r].bt, 0);
            chk($sformatf("row%0d_addr", r), pc_newAddr, tbl[r].na);
            chk($sformatf("row%0d_ack", r), irq_ack, tbl[r].ack);
            chk($sformatf("row%0d_isr", r), in_isr, tbl[r].isr);
            chk($sformatf("row%0d_ovf", r), ras_overflow, tbl[r].ovf);
            chk($sformatf("row%0d_unf", r), ras_underflow, tbl[r].unf);
        end

        instr(0,0,0,0,1, 9'h000, 9'h055, 3);
        chk("stall_release", pc_newAddr, 9'h055);
        instr(0,0,0,0,0, 9'h000, 9'h000, 0);
        chk("stall_once", pc_newAddr, 9'h056);

        instr(0,0,1,0,0, 9'h1AB, 9'h000, 0);
        instr(1,0,0,0,0, 9'h000, 9'h000, 0);
        chk("pre_rst_we", pc_we, 1);
        #2 reset = 0;
        m_reset();
        #1;
        chk("mid_rst_we", pc_we, 0);
        chk("mid_rst_addr", pc_newAddr, 0);
        chk("mid_rst_isr", in_isr, 0);
        chk("mid_rst_ovf", ras_overflow, 0);
        chk("mid_rst_unf", ras_underflow, 0);
        chk("mid_rst_exec", exec, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        chk("reboot_we", pc_we, 1);
        chk("reboot_addr", pc_newAddr, 9'h000);
        instr(0,1,0,0,0, 9'h000, 9'h000, 0);
        chk("empty_ret_addr", pc_newAddr, 9'h000);
        chk("empty_ret_unf", ras_underflow, 1);

        for (int k = 0; k < 300; k++)
            instr($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(5) == 0, $urandom_range(2) == 0,
                  9'($urandom), 9'($urandom), $urandom_range(3) == 0 ? $urandom_range(1, 2) : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
